// File: rtl/io_issue_queue_if.sv
// Handshake bundle for io_issue_queue.
//   enq_*    : dispatch -> queue micro-op offer (valid/ready).
//   wakeup_* : writeback tag broadcast (valid only, no backpressure).
//   deq_*    : queue -> execution pipe issue (valid/ready).
// Handshake rule for both enq and deq: a transfer happens on the rising
// edge where valid and ready are both high. The sender holds its data
// stable while valid is high. Ready never depends combinationally on
// valid from the same channel.
// The master modport is the environment (dispatch, writeback, pipe).
// The slave modport is the queue.
interface io_issue_queue_if #(
    parameter int PAYLOAD_WIDTH = 64,
    parameter int PREG_WIDTH    = 6
);
    logic                     enq_valid;
    logic                     enq_ready;
    logic [PAYLOAD_WIDTH-1:0] enq_payload;
    logic [PREG_WIDTH-1:0]    enq_src1_prd;
    logic                     enq_src1_rdy;
    logic [PREG_WIDTH-1:0]    enq_src2_prd;
    logic                     enq_src2_rdy;
    logic                     wakeup_valid;
    logic [PREG_WIDTH-1:0]    wakeup_prd;
    logic                     deq_valid;
    logic                     deq_ready;
    logic [PAYLOAD_WIDTH-1:0] deq_payload;

    modport master (
        output enq_valid, enq_payload, enq_src1_prd, enq_src1_rdy,
               enq_src2_prd, enq_src2_rdy, wakeup_valid, wakeup_prd, deq_ready,
        input  enq_ready, deq_valid, deq_payload
    );

    modport slave (
        input  enq_valid, enq_payload, enq_src1_prd, enq_src1_rdy,
               enq_src2_prd, enq_src2_rdy, wakeup_valid, wakeup_prd, deq_ready,
        output enq_ready, deq_valid, deq_payload
    );
endinterface

// File: rtl/io_issue_queue.sv
// In-order issue queue for one execution pipe.
// It holds up to QUEUE_SIZE micro-ops in a circular array that one-hot
// pointers address. It tracks source readiness by snooping writeback
// wakeups. Only the oldest entry can issue, and only once both of its
// sources are ready.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   flush          : synchronous clear. It overrides any enq/deq fire
//                    in the same cycle.
//   q              : enq / wakeup / deq handshake bundle (slave side)
//   enq_ptr_oh     : one-hot slot the next enqueue writes
//   deq_ptr_oh     : one-hot head slot
//   valid_dec      : per-entry valid vector
//   count          : number of occupied entries
module io_issue_queue #(
    parameter int QUEUE_SIZE    = 8,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int PREG_WIDTH    = 6,
    localparam int COUNT_WIDTH  = $clog2(QUEUE_SIZE) + 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    io_issue_queue_if.slave        q,
    output logic [QUEUE_SIZE-1:0]  enq_ptr_oh,
    output logic [QUEUE_SIZE-1:0]  deq_ptr_oh,
    output logic [QUEUE_SIZE-1:0]  valid_dec,
    output logic [COUNT_WIDTH-1:0] count
);
    logic [PAYLOAD_WIDTH-1:0] payload_q  [QUEUE_SIZE];
    logic [PREG_WIDTH-1:0]    src1_prd_q [QUEUE_SIZE];
    logic [PREG_WIDTH-1:0]    src2_prd_q [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]    src1_rdy_q;
    logic [QUEUE_SIZE-1:0]    src2_rdy_q;

    logic                     enq_fire;
    logic                     deq_fire;
    logic                     enq_wake1;
    logic                     enq_wake2;
    logic [QUEUE_SIZE-1:0]    wake1;
    logic [QUEUE_SIZE-1:0]    wake2;
    logic [PAYLOAD_WIDTH-1:0] head_payload;
    logic                     head_issuable;

    // Ready depends only on registered occupancy. This keeps it free of any
    // path from deq_ready, so a full queue never accepts a bypassed enqueue.
    assign q.enq_ready = (count != COUNT_WIDTH'(QUEUE_SIZE));
    assign enq_fire    = q.enq_valid & q.enq_ready & ~flush;
    assign deq_fire    = head_issuable & q.deq_ready & ~flush;

    // A wakeup in the same cycle as the enqueue is folded into the
    // captured ready bit. Otherwise that wakeup would be lost.
    assign enq_wake1 = q.wakeup_valid & (q.enq_src1_prd == q.wakeup_prd);
    assign enq_wake2 = q.wakeup_valid & (q.enq_src2_prd == q.wakeup_prd);

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            wake1[i] = q.wakeup_valid & (src1_prd_q[i] == q.wakeup_prd);
            wake2[i] = q.wakeup_valid & (src2_prd_q[i] == q.wakeup_prd);
        end
    end

    // One-hot AND-OR head mux. It reads registered bits only, so a wakeup
    // makes the head issuable one cycle later at the earliest.
    always_comb begin
        head_payload  = '0;
        head_issuable = 1'b0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            head_payload  = head_payload | (payload_q[i] & {PAYLOAD_WIDTH{deq_ptr_oh[i]}});
            head_issuable = head_issuable |
                            (deq_ptr_oh[i] & valid_dec[i] & src1_rdy_q[i] & src2_rdy_q[i]);
        end
    end

    assign q.deq_valid   = head_issuable;
    assign q.deq_payload = head_payload;

    // Payload and tags are plain storage with no reset. The valid and ready
    // bits below decide whether these values have any meaning.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (enq_fire && enq_ptr_oh[i]) begin
                payload_q[i]  <= q.enq_payload;
                src1_prd_q[i] <= q.enq_src1_prd;
                src2_prd_q[i] <= q.enq_src2_prd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_dec  <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            count      <= '0;
            enq_ptr_oh <= QUEUE_SIZE'(1);
            deq_ptr_oh <= QUEUE_SIZE'(1);
        end else if (flush) begin
            valid_dec  <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            count      <= '0;
            enq_ptr_oh <= QUEUE_SIZE'(1);
            deq_ptr_oh <= QUEUE_SIZE'(1);
        end else begin
            // Enqueue and dequeue never target the same slot. That would
            // need a queue that is both full and empty at once.
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (enq_fire && enq_ptr_oh[i]) begin
                    valid_dec[i]  <= 1'b1;
                    src1_rdy_q[i] <= q.enq_src1_rdy | enq_wake1;
                    src2_rdy_q[i] <= q.enq_src2_rdy | enq_wake2;
                end else begin
                    if (deq_fire && deq_ptr_oh[i]) begin
                        valid_dec[i] <= 1'b0;
                    end
                    src1_rdy_q[i] <= src1_rdy_q[i] | (valid_dec[i] & wake1[i]);
                    src2_rdy_q[i] <= src2_rdy_q[i] | (valid_dec[i] & wake2[i]);
                end
            end
            if (enq_fire) begin
                enq_ptr_oh <= {enq_ptr_oh[QUEUE_SIZE-2:0], enq_ptr_oh[QUEUE_SIZE-1]};
            end
            if (deq_fire) begin
                deq_ptr_oh <= {deq_ptr_oh[QUEUE_SIZE-2:0], deq_ptr_oh[QUEUE_SIZE-1]};
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_io_issue_queue.sv
module tb_io_issue_queue;
    localparam int QS = 4;
    localparam int W  = 16;
    localparam int PW = 6;
    localparam int CW = $clog2(QS) + 1;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic [QS-1:0] enq_ptr_oh;
    logic [QS-1:0] deq_ptr_oh;
    logic [QS-1:0] valid_dec;
    logic [CW-1:0] count;

    io_issue_queue_if #(.PAYLOAD_WIDTH(W), .PREG_WIDTH(PW)) bus ();

    io_issue_queue #(.QUEUE_SIZE(QS), .PAYLOAD_WIDTH(W), .PREG_WIDTH(PW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .q          (bus.slave),
        .enq_ptr_oh (enq_ptr_oh),
        .deq_ptr_oh (deq_ptr_oh),
        .valid_dec  (valid_dec),
        .count      (count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard state and reference pointer model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;
    int           model_enq_idx = 0;
    int           model_deq_idx = 0;
    int           deq_cnt = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [QS-1:0] oh(input int idx);
        logic [QS-1:0] v;
        v = '0;
        v[idx % QS] = 1'b1;
        return v;
    endfunction

    function automatic logic [QS-1:0] exp_valid();
        logic [QS-1:0] v;
        v = '0;
        for (int k = 0; k < exp_q.size(); k++) v[(model_deq_idx + k) % QS] = 1'b1;
        return v;
    endfunction

    // Monitor: it samples at negedge, when the inputs and DUT outputs are
    // stable for the coming posedge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (flush) begin
                exp_q.delete();
                model_enq_idx = 0;
                model_deq_idx = 0;
            end else begin
                if (bus.deq_valid && bus.deq_ready) begin
                    if (exp_q.size() == 0) begin
                        check("deq_unexpected", 64'(1), 64'(0));
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("deq_payload", 64'(bus.deq_payload), 64'(exp_item));
                    end
                    deq_cnt++;
                    model_deq_idx = (model_deq_idx + 1) % QS;
                end
                if (bus.enq_valid && bus.enq_ready) begin
                    exp_q.push_back(bus.enq_payload);
                    model_enq_idx = (model_enq_idx + 1) % QS;
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [W-1:0] p, input logic [PW-1:0] t1, input logic r1,
                       input logic [PW-1:0] t2, input logic r2);
        bus.enq_valid    = 1'b1;
        bus.enq_payload  = p;
        bus.enq_src1_prd = t1;
        bus.enq_src1_rdy = r1;
        bus.enq_src2_prd = t2;
        bus.enq_src2_rdy = r2;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.deq_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        bus.deq_ready = 1'b0;
        check(tag, 64'(exp_q.size()), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
        check({tag, "_valid"}, 64'(valid_dec), 64'(exp_valid()));
        check({tag, "_enq_ptr"}, 64'(enq_ptr_oh), 64'(oh(model_enq_idx)));
        check({tag, "_deq_ptr"}, 64'(deq_ptr_oh), 64'(oh(model_deq_idx)));
    endtask

    int d0;

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        bus.enq_valid = 1'b0;
        bus.enq_payload = '0;
        bus.enq_src1_prd = '0;
        bus.enq_src1_rdy = 1'b0;
        bus.enq_src2_prd = '0;
        bus.enq_src2_rdy = 1'b0;
        bus.wakeup_valid = 1'b0;
        bus.wakeup_prd = '0;
        bus.deq_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // reset state
        check("rst_enq_ready", 64'(bus.enq_ready), 64'(1));
        check("rst_deq_valid", 64'(bus.deq_valid), 64'(0));
        check_state("rst");

        // Fill and drain: all sources ready
        for (int i = 0; i < QS; i++) enq(W'(16'hA000 + i), 6'd1, 1'b1, 6'd2, 1'b1);
        check("full_enq_ready", 64'(bus.enq_ready), 64'(0));
        check("full_count", 64'(count), 64'(4));
        check("full_enq_ptr", 64'(enq_ptr_oh), 64'(4'b0001));
        check_state("full");
        enq(16'hFFFF, 6'd1, 1'b1, 6'd2, 1'b1);   // offered while full: must be ignored
        check("full_no_overflow", 64'(count), 64'(4));
        drain("fill_drain");
        check("fill_drain_deq_ptr", 64'(deq_ptr_oh), 64'(4'b0001));
        check("fill_drain_n", 64'(deq_cnt), 64'(4));

        // Wakeup gating: A waits on tag 5, B is ready but behind A
        bus.deq_ready = 1'b1;
        d0 = deq_cnt;
        enq(16'h0A0A, 6'd5, 1'b0, 6'd7, 1'b1);
        enq(16'h0B0B, 6'd11, 1'b1, 6'd12, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("gate_deq_valid", 64'(bus.deq_valid), 64'(0));
            tick();
        end
        check("gate_no_issue", 64'(deq_cnt - d0), 64'(0));
        check_state("gate");
        bus.wakeup_valid = 1'b1;
        bus.wakeup_prd = 6'd5;
        #1;
        check("gate_same_cycle_blocked", 64'(bus.deq_valid), 64'(0));
        tick();
        bus.wakeup_valid = 1'b0;
        check("gate_next_cycle_valid", 64'(bus.deq_valid), 64'(1));
        drain("gate_drain");
        check("gate_issued", 64'(deq_cnt - d0), 64'(2));

        // Same-cycle wakeup at enqueue
        bus.wakeup_valid = 1'b1;
        bus.wakeup_prd = 6'd9;
        enq(16'h0C0C, 6'd3, 1'b1, 6'd9, 1'b0);
        bus.wakeup_valid = 1'b0;
        check("samecyc_deq_valid", 64'(bus.deq_valid), 64'(1));
        drain("samecyc_drain");

        // Wrap-around with enq and deq firing together at count 2
        enq(16'h1000, 6'd1, 1'b1, 6'd2, 1'b1);
        enq(16'h1001, 6'd1, 1'b1, 6'd2, 1'b1);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq(W'(16'h1002 + i), 6'd1, 1'b1, 6'd2, 1'b1);
            check_state("wrap");
        end
        drain("wrap_drain");

        // Flush with pending handshakes
        for (int i = 0; i < 3; i++) enq(W'(16'h2000 + i), 6'd1, 1'b1, 6'd2, 1'b1);
        d0 = deq_cnt;
        flush = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_payload = 16'h2FFF;
        bus.deq_ready = 1'b1;
        #1;
        check("flush_enq_ready", 64'(bus.enq_ready), 64'(1));
        tick();
        flush = 1'b0;
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(valid_dec), 64'(0));
        check("flush_enq_ptr", 64'(enq_ptr_oh), 64'(4'b0001));
        check("flush_deq_ptr", 64'(deq_ptr_oh), 64'(4'b0001));
        check("flush_no_consume", 64'(deq_cnt - d0), 64'(0));
        check("flush_deq_valid", 64'(bus.deq_valid), 64'(0));
        enq(16'h3030, 6'd1, 1'b1, 6'd2, 1'b1);
        drain("post_flush_drain");

        // Async reset mid-stream
        enq(16'h4000, 6'd1, 1'b1, 6'd2, 1'b1);
        enq(16'h4001, 6'd1, 1'b1, 6'd2, 1'b1);
        check("prerst_count", 64'(count), 64'(2));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid_dec), 64'(0));
        check("arst_deq_valid", 64'(bus.deq_valid), 64'(0));
        check("arst_enq_ready", 64'(bus.enq_ready), 64'(1));
        check("arst_count", 64'(count), 64'(0));
        exp_q.delete();
        model_enq_idx = 0;
        model_deq_idx = 0;
        tick();
        reset_n = 1'b1;
        tick();
        check_state("after_arst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/io_issue_queue.md
Name: io_issue_queue

Overview:
- In-order issue queue for one execution pipe. Sits between rename/dispatch and the in-order dequeue policy/issue select.
- Buffers up to QUEUE_SIZE micro-ops in a circular array addressed by one-hot pointers.
- Tracks source-operand readiness by snooping writeback wakeups.
- Issues only the oldest entry, and only once both of its sources are ready.

Parameters:
- QUEUE_SIZE, 8: entry count; power of two, at least 2.
- PAYLOAD_WIDTH, 64: opaque micro-op payload bits.
- PREG_WIDTH, 6: physical register tag width.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous queue clear.
- enq_valid  in  1  dispatch offers a micro-op.
- enq_ready  out  1  queue can accept.
- enq_payload  in  PAYLOAD_WIDTH  micro-op payload.
- enq_src1_prd  in  PREG_WIDTH  source-1 physical tag.
- enq_src1_rdy  in  1  source 1 already ready at dispatch.
- enq_src2_prd  in  PREG_WIDTH  source-2 physical tag.
- enq_src2_rdy  in  1  source 2 already ready at dispatch.
- wakeup_valid  in  1  writeback broadcast valid.
- wakeup_prd  in  PREG_WIDTH  broadcast tag.
- deq_valid  out  1  head entry is issuable.
- deq_ready  in  1  execution pipe accepts.
- deq_payload  out  PAYLOAD_WIDTH  head payload.
- enq_ptr_oh  out  QUEUE_SIZE  one-hot enqueue slot.
- deq_ptr_oh  out  QUEUE_SIZE  one-hot head slot.
- valid_dec  out  QUEUE_SIZE  per-entry valid vector.
- count  out  clog2(QUEUE_SIZE)+1  occupied entries.

Behaviour:
- Reset (async, reset_n low):
  - valid_dec = 0, all ready bits = 0, count = 0.
  - enq_ptr_oh = deq_ptr_oh = 1 (slot 0).
  - Payload storage is not reset.
  - Outputs: enq_ready = 1, deq_valid = 0.
- enq_ready = (count != QUEUE_SIZE). It is combinational from registered state only and never depends on deq_ready, so there is no enqueue bypass when the queue is full.
- Enqueue fire = enq_valid & enq_ready. At the next edge:
  - the slot at enq_ptr_oh captures payload, both tags and both ready bits, and its valid bit sets;
  - enq_ptr_oh rotates left by 1, wrapping from bit QUEUE_SIZE-1 to bit 0.
- Per-entry ready bit:
  - next = current | (wakeup_valid & tag == wakeup_prd), evaluated for every valid entry;
  - the entry written this cycle uses enq_srcN_rdy | (wakeup_valid & enq_srcN_prd == wakeup_prd), so a same-cycle wakeup is never lost.
- deq_valid = valid[head] & src1_rdy[head] & src2_rdy[head], where head is the slot at deq_ptr_oh. It uses registered bits only: a wakeup in cycle N makes an entry issuable in cycle N+1 at the earliest.
- deq_payload = payload[head], muxed by one-hot AND-OR. Its value is don't-care when deq_valid = 0.
- Dequeue fire = deq_valid & deq_ready. At the next edge valid[head] clears and deq_ptr_oh rotates left by 1 with wrap.
- Younger entries never issue past a non-ready head (strict in-order).
- count update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged when both fire;
  - it never exceeds QUEUE_SIZE or underflows.
- Simultaneous enqueue and dequeue on the same slot cannot occur: that would require the queue to be either full or empty, which blocks one side.
- When empty (count = 0), enq_ptr_oh == deq_ptr_oh.
- Flush (synchronous, highest priority):
  - at the next edge valid_dec = 0, ready bits = 0, count = 0 and both pointers return to slot 0;
  - any enqueue or dequeue fire in the flush cycle is discarded;
  - enq_ready stays at its registered value during the flush cycle.
- Reset asserted mid-operation clears state immediately (asynchronously). Any in-flight handshake is dropped.
- Invariant for assertions: popcount(valid_dec) == count, and valid entries form a contiguous circular run starting at deq_ptr_oh.

Test Plan:
- Fill and drain (QUEUE_SIZE=4, all sources ready): 4 enqueues -> count=4, enq_ready=0, enq_ptr_oh=0001. Then 4 dequeues with deq_ready=1 -> payloads emerge in enqueue order, count=0, deq_ptr_oh=0001.
- Wakeup gating: enqueue A with src1_rdy=0, tag 5, and B with all sources ready. Hold 3 cycles -> deq_valid=0 and B is not issued. Pulse wakeup_prd=5 in cycle N -> deq_valid=1 in cycle N+1, A issues before B.
- Same-cycle wakeup at enqueue: enq_src2_rdy=0, tag 9, with wakeup_valid=1 and wakeup_prd=9 in the same cycle -> entry is issuable the next cycle.
- Wrap-around with simultaneous fire: hold count=2 with enq and deq firing every cycle for 10 cycles -> count stays 2, pointers wrap cleanly through 1000->0001, payload order is preserved.
- Flush with pending handshakes: count=3, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, valid_dec=0, both pointers 0001, and no payload is consumed or stored.
- Async reset mid-stream: drop reset_n between clock edges with count=2 -> valid_dec=0, deq_valid=0 and enq_ready=1 immediately, without waiting for a clock edge.
